// File: rtl/halt_cache_ctrl.sv
// Lookup/refill sequencer for one 8-way halt-tag cache set bank.
// Halt-tag filter, serial main-tag probe, round-robin refill.
module halt_cache_ctrl #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int NSETS  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_hit,
  output logic [LINE_W-1:0] resp_data,
  output logic [2:0]        set_sel,
  input  logic [31:0]       halt_tags,
  input  logic              way_viv,
  input  logic [19:0]       way_mtag,
  input  logic [LINE_W-1:0] way_data,
  output logic [7:0]        way_sel,
  output logic              way_we,
  output logic              way_viv_in,
  output logic [23:0]       way_tag_in,
  output logic [LINE_W-1:0] way_data_in,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_data
);

  typedef enum logic [2:0] {
    IDLE, HALT, PROBE, MISS, FILL, RESP
  } state_t;

  state_t state, stateNext;

  logic [ADDR_W-1:5] addrQ;
  logic [7:0]        cand;
  logic [7:0]        candHalt;
  logic [7:0]        candLow;
  logic [7:0]        candRest;
  logic [LINE_W-1:0] lineQ;
  logic [LINE_W-1:0] respDataQ;
  logic              respHitQ;
  logic [2:0]        rr [NSETS];
  logic [2:0]        setIdx;
  logic              probeHit;
  logic              unusedBits;

  // Offset bits never matter: lines are fetched whole.
  assign unusedBits  = ^req_addr[4:0];

  assign setIdx      = addrQ[7:5];
  assign set_sel     = setIdx;
  assign mem_addr    = {addrQ, 5'b0};
  assign way_tag_in  = addrQ[31:8];
  assign way_data_in = lineQ;
  assign resp_data   = respDataQ;
  assign resp_hit    = respHitQ;

  // Halt-tag compare of all ways and lowest-candidate pick
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      candHalt[i] = (halt_tags[4*i +: 4] == addrQ[11:8]);
    end
    candLow  = cand & (~cand + 8'd1);
    candRest = cand & ~candLow;
    probeHit = way_viv && (way_mtag == addrQ[31:12]);
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  // Next state and array/memory/handshake strobes
  always_comb begin
    stateNext  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_req    = 1'b0;
    way_we     = 1'b0;
    way_viv_in = 1'b0;
    way_sel    = '0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) stateNext = HALT;
      end
      HALT: begin
        stateNext = (candHalt == 8'd0) ? MISS : PROBE;
      end
      PROBE: begin
        way_sel = candLow;
        if (probeHit)              stateNext = RESP;
        else if (candRest == 8'd0) stateNext = MISS;
      end
      MISS: begin
        mem_req = 1'b1;
        if (mem_ack) stateNext = FILL;
      end
      FILL: begin
        way_sel    = 8'd1 << rr[setIdx];
        way_we     = 1'b1;
        way_viv_in = 1'b1;
        stateNext  = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Request latch, candidate set, refill line, response and RR pointers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addrQ     <= '0;
      cand      <= '0;
      lineQ     <= '0;
      respDataQ <= '0;
      respHitQ  <= 1'b0;
      for (int s = 0; s < NSETS; s++) rr[s] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) addrQ <= req_addr[ADDR_W-1:5];
        end
        HALT: cand <= candHalt;
        PROBE: begin
          if (probeHit) begin
            respDataQ <= way_data;
            respHitQ  <= 1'b1;
          end else begin
            cand <= candRest;
          end
        end
        MISS: begin
          if (mem_ack) lineQ <= mem_data;
        end
        FILL: begin
          rr[setIdx] <= rr[setIdx] + 3'd1;
          respDataQ  <= lineQ;
          respHitQ   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
